// File: rtl/ksa_pkg.sv
// +----------------------------------------------------------------------+
// | ksa_pkg: shared state encoding and digit width for the serial KSA.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ksa_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : ksa_pkg

`default_nettype wire

// File: rtl/ksa_4bit.sv
// +----------------------------------------------------------------------+
// | ksa_4bit: 4-bit Kogge-Stone adder slice, exposes carry into bit 3.   |
// | Rev 1.1                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ksa_4bit
  import ksa_pkg::*;
(
  input  logic [DIG_W-1:0] a_i,
  input  logic [DIG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [DIG_W-1:0] sum_o,
  output logic             cout_o,
  output logic             c3_o
);

  logic [DIG_W-1:0] w_p;
  logic [DIG_W-1:0] w_g;
  logic [DIG_W-1:0] w_g1;
  logic [DIG_W-1:0] w_p1;
  logic [DIG_W-1:0] w_g2;
  logic [DIG_W:0]   w_c;

  // Carry-in folded into bit-0 generate so the prefix tree needs no extra column.
  assign w_p = a_i ^ b_i;
  assign w_g = (a_i & b_i) | {{(DIG_W-1){1'b0}}, w_p[0] & cin_i};

  assign w_g1[0] = w_g[0];
  assign w_p1[0] = w_p[0];
  for (genvar i = 1; i < DIG_W; i++) begin : g_lvl1
    assign w_g1[i] = w_g[i] | (w_p[i] & w_g[i-1]);
    assign w_p1[i] = w_p[i] & w_p[i-1];
  end

  for (genvar i = 0; i < DIG_W; i++) begin : g_lvl2
    if (i >= 2) begin : g_span
      assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
    end else begin : g_pass
      assign w_g2[i] = w_g1[i];
    end
  end

  assign w_c   = {w_g2, cin_i};
  assign sum_o  = w_p ^ w_c[DIG_W-1:0];
  assign cout_o = w_c[DIG_W];
  assign c3_o   = w_c[DIG_W-1];

endmodule : ksa_4bit

`default_nettype wire

// File: rtl/ksa_serial_add_ctrl.sv
// +----------------------------------------------------------------------+
// | ksa_serial_add_ctrl: digit-serial add/sub around one ksa_4bit slice. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ksa_serial_add_ctrl
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIG_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  if ((WIDTH % DIG_W) != 0 || WIDTH < 8) begin : g_width_check
    $error("ksa_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic [DIG_W-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_c3;

  ksa_4bit u_slice (
    .a_i    (a_q[idx_q*DIG_W +: DIG_W]),
    .b_i    (b_q[idx_q*DIG_W +: DIG_W]),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout),
    .c3_o   (dig_c3)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so cin is irrelevant for op_sub.
          state_d = RUN;
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        sum_d[idx_q*DIG_W +: DIG_W] = dig_sum;
        carry_d = dig_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_cout;
          ovf_d   = dig_c3 ^ dig_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : ksa_serial_add_ctrl

`default_nettype wire

// File: tb/tb_ksa_serial_add_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_ksa_serial_add_ctrl: directed scoreboard bench for the serial KSA.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ksa_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  ksa_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mcin, input logic msub);
    exp_t             r;
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;
    bb   = msub ? ~mb : mb;
    c0   = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
    low  = {1'b0, ma[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c0};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = low[WIDTH-1] ^ full[WIDTH];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one accept edge; optionally records the expected result.
  task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb_in,
                      input logic scin, input logic ssub, input bit push);
    a        = sa;
    b        = sb_in;
    cin      = scin;
    op_sub   = ssub;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    if (push) sb.push_back(model(sa, sb_in, scin, ssub));
  endtask

  // Expects out_valid exactly LAT cycles after the accept edge, then compares.
  task automatic await_result(input string tag);
    exp_t e;
    int   extra;
    for (int k = 1; k < LAT; k++) begin
      tick();
      chk({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
    end
    tick();
    chk({tag, "_valid_at_latency"}, 32'(out_valid), 32'd1);
    extra = 0;
    while (!out_valid && extra < 30) begin
      tick();
      extra++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_sum"},  32'(sum),  32'(e.sum));
    chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
    chk({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();

    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    rst_n = 1'b1;
    tick();

    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    await_result("add_basic");
    release_result("add_basic");

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    await_result("add_ripple");
    release_result("add_ripple");

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    await_result("add_ovf");
    release_result("add_ovf");

    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    await_result("sub_ovf");
    release_result("sub_ovf");

    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    await_result("sub_borrow");
    release_result("sub_borrow");

    send(16'hA5C3, 16'h5A3D, 1'b1, 1'b0, 1'b1);
    await_result("add_cin");

    // Back-pressure: DONE must hold while a competing request is refused.
    held     = sum;
    a        = 16'h0F0F;
    b        = 16'h0101;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_sum_held",  32'(sum),       32'(held));
    end
    in_valid = 1'b0;
    release_result("bp");
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1);
    await_result("after_bp");
    release_result("after_bp");

    // Reset during the second RUN cycle discards the operation.
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("midrun_partial_sum", 32'(sum != 16'h0), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun_in_ready",  32'(in_ready),  32'd1);
    chk("midrun_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_sum",       32'(sum),       32'd0);
    chk("midrun_cout",      32'(cout),      32'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("midrun_no_valid", 32'(out_valid), 32'd0);
    end

    send(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    await_result("post_reset");
    release_result("post_reset");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ksa_serial_add_ctrl

`default_nettype wire
